vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Parametrised successor to the fixed-function 3-bit demo painter.
- Sits between the `vga` timing generator (consumes its ptick/ftick/active/xpos/ypos) and its pixel_rgb input.
- Generates 16 test patterns at configurable colour depth, with scaled banner text, checker/bar geometry and two gradient patterns.
- Pattern sequencing runs either automatically (dwell timer in frames) or manually (step pulses). All logic is synchronous to one clock, using ptick/ftick as enables rather than clocks.

Parameters:
- COLOR_BITS, 1, bits per channel (1..8); pixel width is 3*COLOR_BITS.
- DWELL_FRAMES, 60, frames per pattern in auto mode (1..255).
- TXT_SCALE_LOG2, 2, banner block size is 2^TXT_SCALE_LOG2 pixels square (0..3).
- TXT_X, 40, banner left edge, in blocks.
- TXT_Y, 55, banner top edge, in blocks.
- CHECK_LOG2, 5, checker square size is 2^CHECK_LOG2 pixels (2..7).
- BAR_LOG2, 5, bar width is 2^BAR_LOG2 pixels (2..6).

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- ptick  in  1  one-clk pixel enable from `vga`.
- ftick  in  1  one-clk frame pulse from `vga` (start of blanking).
- active  in  1  visible-area flag.
- xpos  in  10  current pixel column.
- ypos  in  10  current pixel row.
- auto_en  in  1  1 = dwell-timer sequencing; 0 = manual.
- step  in  1  one-clk pulse; advances the pattern by 1 (active in both modes).
- pixel  out  3*COLOR_BITS  {R,G,B}, registered.
- pattern  out  4  current pattern index.
- pattern_chg  out  1  one-clk pulse when the pattern index changes.

Behaviour:
- Reset (async assert, sync release): pixel=0, pattern=0, pattern_chg=0, dwell counter=0.
- Pixel pipeline:
  - pixel updates only on clk edges where ptick=1; otherwise it holds.
  - Latency is 1 ptick-qualified clk from (xpos, ypos, active) to pixel.
  - active=0 gives pixel=0.
- Colour expansion: 3-bit index c maps to each channel being all-ones if its bit is set, else zero (R=c[2], G=c[1], B=c[0]).
- Patterns:
  - 0: banner. Block coordinates are bx = xpos>>TXT_SCALE_LOG2 and by = ypos>>TXT_SCALE_LOG2. Inside the region TXT_X <= bx < TXT_X+80 and TXT_Y <= by < TXT_Y+7, the ROM bit at (bx-TXT_X, by-TXT_Y) selects white (1) or black (0). Outside the region, pixel = 0.
  - 1..7: solid, expand(pattern[2:0]).
  - 8..11: checker. Let k = {1'b0, pattern[1:0]}. If xpos[CHECK_LOG2]^ypos[CHECK_LOG2] then expand(k), else expand(~k).
  - 12: vertical bars, expand(xpos[BAR_LOG2+2:BAR_LOG2] + 3'd4), mod 8.
  - 13: horizontal bars, expand(ypos[BAR_LOG2+2:BAR_LOG2] + 3'd5), mod 8.
  - 14: red ramp. R = xpos[9 -: COLOR_BITS], G = B = 0.
  - 15: grey ramp. R = G = B = ypos[8 -: COLOR_BITS].
- Sequencer:
  - Dwell counter is 8-bit and counts on ftick when auto_en=1.
  - When the counter reaches DWELL_FRAMES-1 on an ftick, the counter clears and pattern increments.
  - pattern wraps from 15 to 0.
  - step=1 increments pattern and clears the dwell counter.
  - step and a dwell expiry in the same clk produce a single increment, not two.
  - auto_en=0 freezes the dwell counter at its current value; it resumes on re-enable.
  - Pattern changes take effect on pixels at the next ptick. There is no frame alignment for step.
  - pattern_chg is high for exactly the clk in which pattern is updated.
- Reset mid-frame: outputs go to 0 immediately (async). Painting restarts with pattern 0 at the next ptick after release.

Optional Feature:
- VGA_PATTERN_SCROLL_EN
- Defined:
  - Adds a 7-bit scroll offset, reset to 0, incremented on each ftick while pattern==0, wrapping 79 to 0.
  - Banner column becomes (bx-TXT_X+offset) mod 80, giving a horizontal scroll of one block per frame.
  - The offset clears whenever pattern leaves 0.
- Undefined: the banner is static; no offset register exists.

Decomposition:
- Package vga_pattern_pkg holds:
  - pattern index localparams: PAT_TEXT=0, PAT_CHECK_BASE=8, PAT_VBARS=12, PAT_HBARS=13, PAT_RRAMP=14, PAT_GRAMP=15;
  - TXT_W=80 and TXT_H=7;
  - the expand function for 3-bit colours.
- Sub-module vga_text_rom: combinational 80x7 banner ROM. Inputs are row (3 bits) and col (7 bits); output is bit (1). Rows 7+ and cols 80+ return 0.

Test Plan:
- Reset release, auto_en=1, DWELL_FRAMES=3, 7 ftick pulses -> pattern 0,0,0,1,1,1,2; pattern_chg pulses after ftick #3 and #6.
- pattern=3, COLOR_BITS=4, active=1, ptick -> pixel=12'h0FF; active=0 -> pixel=0 at the next ptick.
- Pattern 9, CHECK_LOG2=5: xpos=0,ypos=0 -> expand(3'b110); xpos=32,ypos=0 -> expand(3'b001).
- step asserted in the same clk as the dwell-expiry ftick at pattern 15 -> pattern=0 (single increment), dwell counter=0.
- Pattern 0, TXT_SCALE_LOG2=2: xpos=160,ypos=220 (block 40,55) -> white; xpos=159 -> black.
- reset_n pulsed low mid-line with pattern=14 -> pixel=0 and pattern=0 asynchronously; pattern 0 resumes after release.

Source files
------------

// File: rtl/vga_pattern_gen_pkg.sv
// Shared constants, glyph codes and colour expansion for the VGA test-pattern generator.
package vga_pattern_pkg;

    localparam logic [3:0] PAT_TEXT       = 4'd0;
    localparam logic [3:0] PAT_CHECK_BASE = 4'd8;
    localparam logic [3:0] PAT_VBARS      = 4'd12;
    localparam logic [3:0] PAT_HBARS      = 4'd13;
    localparam logic [3:0] PAT_RRAMP      = 4'd14;
    localparam logic [3:0] PAT_GRAMP      = 4'd15;

    localparam int TXT_W = 80;
    localparam int TXT_H = 7;

    typedef enum logic [3:0] {
        GL_SPACE,
        GL_P,
        GL_A,
        GL_T,
        GL_E,
        GL_R,
        GL_N,
        GL_1,
        GL_6
    } glyph_t;

    // Each channel of the result is 8 bits wide; callers keep the low COLOR_BITS of each.
    function automatic logic [23:0] expand(input logic [2:0] c);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Timing bundle coming from the vga timing generator into the pattern generator.
interface vga_pattern_gen_if;

    logic       ptick;
    logic       ftick;
    logic       active;
    logic [9:0] xpos;
    logic [9:0] ypos;

    modport master (output ptick, ftick, active, xpos, ypos);
    modport slave  (input  ptick, ftick, active, xpos, ypos);

endinterface

// File: rtl/vga_text_rom.sv
// Combinational 80x7 banner ROM spelling "PATTERN 16" in 5x7 glyphs on 8-column cells.
module vga_text_rom
    import vga_pattern_pkg::*;
(
    input  logic [2:0] row,
    input  logic [6:0] col,
    output logic       rom_bit
);

    glyph_t      glyph;
    logic [34:0] glyph_bits;
    logic [34:0] shifted;
    logic [5:0]  shamt;
    logic [7:0]  cell_row;

    function automatic logic [34:0] glyph_rows(input glyph_t g);
        case (g)
            GL_P:    return 35'b11110_10001_10001_11110_10000_10000_10000;
            GL_A:    return 35'b01110_10001_10001_11111_10001_10001_10001;
            GL_T:    return 35'b11111_00100_00100_00100_00100_00100_00100;
            GL_E:    return 35'b11111_10000_10000_11110_10000_10000_11111;
            GL_R:    return 35'b11110_10001_10001_11110_10100_10010_10001;
            GL_N:    return 35'b10001_11001_10101_10011_10001_10001_10001;
            GL_1:    return 35'b00100_01100_00100_00100_00100_00100_01110;
            GL_6:    return 35'b00110_01000_10000_11110_10001_10001_01110;
            default: return '0;
        endcase
    endfunction

    // Cells 10..15 cover columns 80..127 and stay blank; row 7 shifts everything out.
    always_comb begin
        case (col[6:3])
            4'd0:    glyph = GL_P;
            4'd1:    glyph = GL_A;
            4'd2:    glyph = GL_T;
            4'd3:    glyph = GL_T;
            4'd4:    glyph = GL_E;
            4'd5:    glyph = GL_R;
            4'd6:    glyph = GL_N;
            4'd8:    glyph = GL_1;
            4'd9:    glyph = GL_6;
            default: glyph = GL_SPACE;
        endcase
        glyph_bits = glyph_rows(glyph);
        shamt      = 6'(row) * 6'd5;
        shifted    = glyph_bits << shamt;
        cell_row   = {shifted[34:30], 3'b000};
        rom_bit    = cell_row[3'd7 - col[2:0]];
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA test-pattern generator with dwell/step sequencing.
// Optional banner scrolling is enabled by defining VGA_PATTERN_SCROLL_EN.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int COLOR_BITS     = 1,
    parameter int DWELL_FRAMES   = 60,
    parameter int TXT_SCALE_LOG2 = 2,
    parameter int TXT_X          = 40,
    parameter int TXT_Y          = 55,
    parameter int CHECK_LOG2     = 5,
    parameter int BAR_LOG2       = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,
    vga_pattern_gen_if.slave          vga,
    input  logic                      auto_en,
    input  logic                      step,
    output logic [3*COLOR_BITS-1:0]   pixel,
    output logic [3:0]                pattern,
    output logic                      pattern_chg
);

    localparam int CB = COLOR_BITS;
    localparam logic [10:0] TX_LO = 11'(TXT_X);
    localparam logic [10:0] TX_HI = 11'(TXT_X + TXT_W);
    localparam logic [10:0] TY_LO = 11'(TXT_Y);
    localparam logic [10:0] TY_HI = 11'(TXT_Y + TXT_H);
    localparam logic [7:0]  DWELL_LAST = 8'(DWELL_FRAMES - 1);

    logic [7:0]        dwell_cnt;
    logic              dwell_expire;
    logic              advance;
    logic [9:0]        bx;
    logic [9:0]        by;
    logic [9:0]        bx_rel;
    logic [9:0]        by_rel;
    logic              in_banner;
    logic [6:0]        rom_col;
    logic              rom_bit;
    logic [2:0]        cidx;
    logic [23:0]       ex;
    logic [3*CB-1:0]   pix_next;
    logic              unused_bits;

    // Step and dwell expiry share one increment so they can never double-count.
    assign dwell_expire = auto_en && vga.ftick && (dwell_cnt == DWELL_LAST);
    assign advance      = step || dwell_expire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern     <= PAT_TEXT;
            dwell_cnt   <= '0;
            pattern_chg <= 1'b0;
        end else if (advance) begin
            pattern     <= pattern + 4'd1;
            dwell_cnt   <= '0;
            pattern_chg <= 1'b1;
        end else begin
            pattern_chg <= 1'b0;
            if (auto_en && vga.ftick)
                dwell_cnt <= dwell_cnt + 8'd1;
        end
    end

    assign bx        = vga.xpos >> TXT_SCALE_LOG2;
    assign by        = vga.ypos >> TXT_SCALE_LOG2;
    assign bx_rel    = bx - TX_LO[9:0];
    assign by_rel    = by - TY_LO[9:0];
    assign in_banner = ({1'b0, bx} >= TX_LO) && ({1'b0, bx} < TX_HI) &&
                       ({1'b0, by} >= TY_LO) && ({1'b0, by} < TY_HI);

`ifdef VGA_PATTERN_SCROLL_EN
    logic [6:0] scroll_off;
    logic [7:0] col_sum;
    logic [7:0] col_wrap;

    // Offset advances one block per frame while the banner is showing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            scroll_off <= '0;
        else if (pattern != PAT_TEXT)
            scroll_off <= '0;
        else if (vga.ftick)
            scroll_off <= (scroll_off == 7'(TXT_W - 1)) ? 7'd0 : scroll_off + 7'd1;
    end

    always_comb begin
        col_sum  = {1'b0, bx_rel[6:0]} + {1'b0, scroll_off};
        col_wrap = (col_sum >= 8'(TXT_W)) ? col_sum - 8'(TXT_W) : col_sum;
        rom_col  = col_wrap[6:0];
    end

    assign unused_bits = ^{vga.xpos, vga.ypos, bx_rel[9:7], by_rel[9:3], col_wrap[7]};
`else
    assign rom_col     = bx_rel[6:0];
    assign unused_bits = ^{vga.xpos, vga.ypos, bx_rel[9:7], by_rel[9:3]};
`endif

    vga_text_rom u_rom (
        .row     (by_rel[2:0]),
        .col     (rom_col),
        .rom_bit (rom_bit)
    );

    // Indexed patterns pick a 3-bit colour; the two ramps bypass the palette.
    always_comb begin
        cidx = 3'd0;
        if (pattern == PAT_TEXT)
            cidx = (in_banner && rom_bit) ? 3'b111 : 3'b000;
        else if (pattern < PAT_CHECK_BASE)
            cidx = pattern[2:0];
        else if (pattern < PAT_VBARS)
            cidx = (vga.xpos[CHECK_LOG2] ^ vga.ypos[CHECK_LOG2]) ?
                   {1'b0, pattern[1:0]} : ~{1'b0, pattern[1:0]};
        else if (pattern == PAT_VBARS)
            cidx = vga.xpos[BAR_LOG2+2 -: 3] + 3'd4;
        else if (pattern == PAT_HBARS)
            cidx = vga.ypos[BAR_LOG2+2 -: 3] + 3'd5;

        ex       = expand(cidx);
        pix_next = {ex[16 +: CB], ex[8 +: CB], ex[0 +: CB]};

        if (pattern == PAT_RRAMP)
            pix_next = {vga.xpos[9 -: CB], {(2*CB){1'b0}}};
        else if (pattern == PAT_GRAMP)
            pix_next = {3{vga.ypos[8 -: CB]}};

        if (!vga.active)
            pix_next = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pixel <= '0;
        else if (vga.ptick)
            pixel <= pix_next;
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed self-checking bench for vga_pattern_gen (COLOR_BITS=4, DWELL_FRAMES=3).
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        auto_en = 1'b0;
    logic        step = 1'b0;
    logic [11:0] pixel;
    logic [3:0]  pattern;
    logic        pattern_chg;
    int          total = 0;
    int          bad = 0;

    vga_pattern_gen_if vif ();

    vga_pattern_gen #(
        .COLOR_BITS   (4),
        .DWELL_FRAMES (3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .vga         (vif),
        .auto_en     (auto_en),
        .step        (step),
        .pixel       (pixel),
        .pattern     (pattern),
        .pattern_chg (pattern_chg)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one clock of inputs, then drops the one-clk pulses at posedge+1.
    task automatic apply_stimulus(input logic p, input logic f, input logic a,
                                  input logic [9:0] x, input logic [9:0] y, input logic s);
        vif.ptick  = p;
        vif.ftick  = f;
        vif.active = a;
        vif.xpos   = x;
        vif.ypos   = y;
        step       = s;
        @(posedge clk);
        #1;
        vif.ptick = 1'b0;
        vif.ftick = 1'b0;
        step      = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_pat [7];
        logic       exp_chg [7];
        exp_pat = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        exp_chg = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        vif.ptick = 1'b0; vif.ftick = 1'b0; vif.active = 1'b0;
        vif.xpos = '0; vif.ypos = '0;

        #2 reset_n = 1'b0;
        #20;
        check_output("rst_pixel", 32'(pixel), 32'h0);
        check_output("rst_pattern", 32'(pattern), 32'h0);
        check_output("rst_chg", 32'(pattern_chg), 32'h0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        auto_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check_output($sformatf("dwell_pat%0d", i), 32'(pattern), 32'(exp_pat[i]));
            apply_stimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
            check_output($sformatf("dwell_chg%0d", i), 32'(pattern_chg), 32'(exp_chg[i]));
        end

        // Counter sits at 1; frozen fticks must not advance it.
        auto_en = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
        check_output("freeze_pat", 32'(pattern), 32'd2);
        auto_en = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
        check_output("resume_pat_a", 32'(pattern), 32'd2);
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
        check_output("resume_pat_b", 32'(pattern), 32'd3);
        auto_en = 1'b0;

        apply_stimulus(1'b1, 1'b0, 1'b1, 10'd0, 10'd0, 1'b0);
        check_output("solid3", 32'(pixel), 32'h0FF);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        check_output("hold_no_ptick", 32'(pixel), 32'h0FF);
        apply_stimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        check_output("blank", 32'(pixel), 32'h000);

        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        check_output("step_pat9", 32'(pattern), 32'd9);
        check_output("step_chg", 32'(pattern_chg), 32'd1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'd0, 10'd0, 1'b0);
        check_output("check_00", 32'(pixel), 32'hFF0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'd32, 10'd0, 1'b0);
        check_output("check_32_0", 32'(pixel), 32'h00F);
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'd32, 10'd32, 1'b0);
        check_output("check_32_32", 32'(pixel), 32'hFF0);

        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'd0, 10'd0, 1'b0);
        check_output("vbar_x0", 32'(pixel), 32'hF00);
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'd64, 10'd0, 1'b0);
        check_output("vbar_x64", 32'(pixel), 32'hFF0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'd0, 10'd0, 1'b0);
        check_output("hbar_y0", 32'(pixel), 32'hF0F);
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'd0, 10'd32, 1'b0);
        check_output("hbar_y32", 32'(pixel), 32'hFF0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'h2A5, 10'd0, 1'b0);
        check_output("rramp", 32'(pixel), 32'hA00);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'd0, 10'h0A0, 1'b0);
        check_output("gramp", 32'(pixel), 32'h555);
        check_output("pat15", 32'(pattern), 32'd15);

        // Dwell counter starts at 0 after the last step; bring it to 2 then collide.
        auto_en = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
        check_output("pre_collide_pat", 32'(pattern), 32'd15);
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b1);
        check_output("collide_pat", 32'(pattern), 32'd0);
        check_output("collide_chg", 32'(pattern_chg), 32'd1);
        auto_en = 1'b0;

        apply_stimulus(1'b1, 1'b0, 1'b1, 10'd160, 10'd220, 1'b0);
        check_output("banner_in", 32'(pixel), 32'hFFF);
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'd159, 10'd220, 1'b0);
        check_output("banner_left", 32'(pixel), 32'h000);
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'd196, 10'd220, 1'b0);
        check_output("banner_a", 32'(pixel), 32'hFFF);
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'd160, 10'd219, 1'b0);
        check_output("banner_above", 32'(pixel), 32'h000);

        auto_en = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
        check_output("post_collide_hold", 32'(pattern), 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
        check_output("post_collide_adv", 32'(pattern), 32'd1);
        auto_en = 1'b0;

        for (int i = 0; i < 13; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'h2A5, 10'd0, 1'b0);
        check_output("pre_reset_pixel", 32'(pixel), 32'hA00);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_pixel", 32'(pixel), 32'h000);
        check_output("async_pattern", 32'(pattern), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'd160, 10'd220, 1'b0);
        check_output("resume_banner", 32'(pixel), 32'hFFF);
        check_output("resume_pattern", 32'(pattern), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
